vco_band_cal: RTL
=================

# vco_band_cal

Digital band-calibration controller for the CDR VCO, the parametrised successor to the fixed 5-bit tuned VCO. It owns the VCO coarse `tune` code, which is now `TUNE_W` bits wide. On request it finds the band whose free-running frequency best matches a programmable target. It does this by successive approximation: it counts edges of a divided VCO clock over a reference-clock window, and it holds the analog loop at mid-rail (`vcoin_hold`) during calibration. The block sits between the CDR control logic and the VCO model/divider.

## Interface
- `TUNE_W`, 5: width of `tune`.
- `CNT_W`, 12: width of the edge counter and `target_cnt`.
- `WIN_CYCLES`, 256: `clk` cycles per measurement window.
- `SETTLE_CYCLES`, 16: `clk` cycles waited after each `tune` change before measuring.
- `TOL`, 2: maximum allowed |meas − target| at final verify.
- `clk`  in  1  reference clock; the only clock of the block.
- `rst`  in  1  reset; asynchronous, active-high.
- `cal_start`  in  1  one-cycle start request.
- `target_cnt`  in  CNT_W  expected divided-VCO edges per window; sampled on accepted start.
- `vco_div`  in  1  divided VCO clock, asynchronous to `clk`; frequency < f(clk)/2.
- `tune`  out  TUNE_W  VCO band code.
- `cal_busy`  out  1  calibration in progress.
- `cal_done`  out  1  sticky; set at end of calibration, cleared by the next accepted start.
- `cal_fail`  out  1  sticky; final verify out of tolerance.
- `meas_cnt`  out  CNT_W  result of the most recent window.
- `vcoin_hold`  out  1  request to force VcoIn to its mid voltage; equals `cal_busy`.

## Operation
- Reset values:
  - `tune` = 2^(TUNE_W−1)−1, which is 15 for width 5 (neutral band).
  - `cal_busy`, `cal_done`, `cal_fail`, `vcoin_hold` = 0.
  - `meas_cnt` = 0.
  - FSM in IDLE.
- Edge capture: `vco_div` passes through a 2-flop synchronizer plus 1 history flop. A rising edge is detected when sync = 1 and history = 0.
- FSM states: IDLE, SETTLE, MEASURE, DECIDE, DONE.
  - IDLE: `cal_start` is accepted. Then:
    - latch `target_cnt`;
    - set bit pointer b = TUNE_W−1;
    - set `tune` = 1<<b;
    - clear `cal_done` and `cal_fail`;
    - go to SETTLE.
  - SETTLE: count SETTLE_CYCLES cycles, then go to MEASURE. The edge counter is cleared on entry to MEASURE.
  - MEASURE: count detected edges for exactly WIN_CYCLES cycles. The counter saturates at 2^CNT_W−1 and does not wrap. At the end, copy the count to `meas_cnt` and go to DECIDE.
  - DECIDE, SAR step (b ≥ 0):
    - if `meas_cnt` > target, clear bit b; otherwise keep it;
    - if b > 0, set bit b−1, decrement b, and go to SETTLE;
    - if b = 0, enter the verify phase: go to SETTLE with `tune` unchanged.
  - DECIDE, verify phase: set `cal_fail` = (|meas_cnt − target| > TOL). Go to DONE.
  - DONE: pulse-free. Set `cal_done` = 1, drop `cal_busy`, and return to IDLE on the next cycle. `tune` holds its final value.
- `cal_start` is ignored while `cal_busy` = 1.
- `rst` asserted at any time, including mid-MEASURE, immediately forces all reset values. A partial calibration is discarded.
- `tune` changes only on entry to SETTLE.

## Timing
- `cal_start` sampled high in cycle N: `cal_busy` = 1 and `tune` = 1<<(TUNE_W−1) from N+1.
- Each measurement takes SETTLE_CYCLES + WIN_CYCLES + 1 (DECIDE) cycles.
- There are TUNE_W+1 measurements. Total busy = (TUNE_W+1)·(SETTLE_CYCLES+WIN_CYCLES+1) + 1 cycles, which is 1639 for the defaults.
- Edge-detect latency is 3 `clk` cycles. Edges in the last 3 cycles of a window are lost, and edges from settle may appear in the first 3 cycles of a window. This error is accepted and covered by `TOL`.
- `cal_done` and `cal_busy` transition in the same cycle.

## Structure
- Package `vco_cal_pkg`:
  - FSM state enum `cal_state_t`;
  - function `tune_mid(TUNE_W)` returning the reset code.
- Sub-module `edge_sync`: 2-flop synchronizer plus rising-edge detector, async active-high reset. Output is a single-cycle `edge` pulse.
- Top level contains the FSM, the settle/window counter (sized for max(SETTLE_CYCLES, WIN_CYCLES)), the saturating edge counter, and the SAR register.

## Test plan
- Reset: assert `rst` mid-run. All outputs are at reset values immediately (`tune` = 15), and the FSM is in IDLE.
- Linear model (bench drives `vco_div` so that count = 100 + 4·tune per window), `target_cnt` = 160: SAR sequence is 16→8→12→14→15. Final `tune` = 15, `meas_cnt` = 160, done = 1, fail = 0, busy for 1639 cycles.
- Same model, `target_cnt` = 50: `tune` = 0, fail = 1, done = 1.
- Same model, `target_cnt` = 400: `tune` = 31, fail = 1.
- Pulse `cal_start` while busy: no restart, same result as the first calibration. A new start after done clears `cal_done`/`cal_fail` on the next cycle.
- `CNT_W` = 6 with `vco_div` at f(clk)/4 over 256 cycles: `meas_cnt` saturates at 63 with no wrap. `vcoin_hold` tracks `cal_busy` throughout.

Source files
------------

// File: rtl/vco_band_cal_pkg.sv
// Shared types and helpers for the VCO band-calibration controller.
//   cal_state_t : calibration FSM state encoding
//   tune_mid()  : neutral band code loaded at reset, 2^(w-1)-1
package vco_cal_pkg;

  typedef enum logic [2:0] {
    CAL_IDLE,
    CAL_SETTLE,
    CAL_MEASURE,
    CAL_DECIDE,
    CAL_DONE
  } cal_state_t;

  function automatic int unsigned tune_mid(input int unsigned w);
    return (32'd1 << (w - 32'd1)) - 32'd1;
  endfunction

endpackage

// File: rtl/vco_band_cal_edge_sync.sv
// Two-flop synchronizer plus history flop for the divided VCO clock.
// Produces a single-cycle pulse in the clk domain for each rising edge.
//   clk        : reference clock
//   rst        : asynchronous active-high reset
//   async_in   : divided VCO clock, asynchronous to clk
//   edge_pulse : one-cycle pulse per detected rising edge
module edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic edge_pulse
);

  logic sync1;
  logic sync2;
  logic hist;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      hist  <= 1'b0;
    end else begin
      sync1 <= async_in;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  assign edge_pulse = sync2 & ~hist;

endmodule

// File: rtl/vco_band_cal.sv
// VCO coarse-band calibration by successive approximation. Each step settles,
// counts divided-VCO edges over a fixed window, and trims one tune bit; a final
// measurement at the chosen code checks it against the target within TOL.
//   clk, rst     : reference clock, asynchronous active-high reset
//   cal_start    : one-cycle start request (ignored while busy)
//   target_cnt   : expected edges per window, latched on accepted start
//   vco_div      : divided VCO clock (asynchronous)
//   tune         : VCO band code
//   cal_busy     : calibration in progress
//   cal_done     : sticky completion flag
//   cal_fail     : sticky verify-out-of-tolerance flag
//   meas_cnt     : edge count of the most recent window
//   vcoin_hold   : hold VcoIn at mid-rail, same as cal_busy
//
// state   | meaning
// IDLE    | waiting for cal_start
// SETTLE  | VCO settling after a tune change
// MEASURE | counting edges over the window
// DECIDE  | SAR bit decision, or verify check after the last bit
// DONE    | one cycle before returning to IDLE; raises cal_done
module vco_band_cal
  import vco_cal_pkg::*;
#(
  parameter int TUNE_W        = 5,
  parameter int CNT_W         = 12,
  parameter int WIN_CYCLES    = 256,
  parameter int SETTLE_CYCLES = 16,
  parameter int TOL           = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cal_start,
  input  logic [CNT_W-1:0]  target_cnt,
  input  logic              vco_div,
  output logic [TUNE_W-1:0] tune,
  output logic              cal_busy,
  output logic              cal_done,
  output logic              cal_fail,
  output logic [CNT_W-1:0]  meas_cnt,
  output logic              vcoin_hold
);

  localparam int MAX_CYC = (SETTLE_CYCLES > WIN_CYCLES) ? SETTLE_CYCLES : WIN_CYCLES;
  localparam int TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int BIT_W   = (TUNE_W > 1) ? $clog2(TUNE_W) : 1;

  localparam logic [TMR_W-1:0]  SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0]  WIN_LOAD    = TMR_W'(WIN_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX     = '1;
  localparam logic [TUNE_W-1:0] TUNE_RST    = TUNE_W'(tune_mid(TUNE_W));
  localparam logic [TUNE_W-1:0] TUNE_MSB    = TUNE_W'(1) << (TUNE_W - 1);
  localparam logic [BIT_W-1:0]  BIT_TOP     = BIT_W'(TUNE_W - 1);

  cal_state_t        state, state_nx;
  logic [TMR_W-1:0]  tmr, tmr_nx;
  logic [BIT_W-1:0]  bit_ptr, bit_nx;
  logic              verify, verify_nx;
  logic [TUNE_W-1:0] tune_nx, tune_dec;
  logic [CNT_W-1:0]  target, target_nx;
  logic [CNT_W-1:0]  edge_cnt, edge_cnt_nx, cnt_inc;
  logic [CNT_W-1:0]  meas_nx;
  logic              done_nx, fail_nx;
  logic [CNT_W-1:0]  diff;
  logic              out_of_tol;
  logic              edge_pulse;

  edge_sync u_edge_sync (
    .clk        (clk),
    .rst        (rst),
    .async_in   (vco_div),
    .edge_pulse (edge_pulse)
  );

  // Saturate instead of wrapping so a fast band never reads as a slow one.
  assign cnt_inc = (edge_pulse && (edge_cnt != CNT_MAX)) ? edge_cnt + CNT_W'(1) : edge_cnt;

  assign diff       = (meas_cnt > target) ? meas_cnt - target : target - meas_cnt;
  assign out_of_tol = diff > CNT_W'(TOL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= CAL_IDLE;
      tmr      <= '0;
      bit_ptr  <= '0;
      verify   <= 1'b0;
      tune     <= TUNE_RST;
      target   <= '0;
      edge_cnt <= '0;
      meas_cnt <= '0;
      cal_done <= 1'b0;
      cal_fail <= 1'b0;
    end else begin
      state    <= state_nx;
      tmr      <= tmr_nx;
      bit_ptr  <= bit_nx;
      verify   <= verify_nx;
      tune     <= tune_nx;
      target   <= target_nx;
      edge_cnt <= edge_cnt_nx;
      meas_cnt <= meas_nx;
      cal_done <= done_nx;
      cal_fail <= fail_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    tmr_nx      = tmr;
    bit_nx      = bit_ptr;
    verify_nx   = verify;
    tune_nx     = tune;
    tune_dec    = tune;
    target_nx   = target;
    edge_cnt_nx = edge_cnt;
    meas_nx     = meas_cnt;
    done_nx     = cal_done;
    fail_nx     = cal_fail;

    case (state)
      CAL_IDLE: begin
        if (cal_start) begin
          target_nx = target_cnt;
          bit_nx    = BIT_TOP;
          tune_nx   = TUNE_MSB;
          verify_nx = 1'b0;
          done_nx   = 1'b0;
          fail_nx   = 1'b0;
          tmr_nx    = SETTLE_LOAD;
          state_nx  = CAL_SETTLE;
        end
      end

      CAL_SETTLE: begin
        if (tmr == '0) begin
          tmr_nx      = WIN_LOAD;
          edge_cnt_nx = '0;
          state_nx    = CAL_MEASURE;
        end else begin
          tmr_nx = tmr - TMR_W'(1);
        end
      end

      CAL_MEASURE: begin
        // The last window cycle's edge goes straight into meas_cnt.
        if (tmr == '0) begin
          meas_nx  = cnt_inc;
          state_nx = CAL_DECIDE;
        end else begin
          edge_cnt_nx = cnt_inc;
          tmr_nx      = tmr - TMR_W'(1);
        end
      end

      CAL_DECIDE: begin
        if (verify) begin
          fail_nx  = out_of_tol;
          state_nx = CAL_DONE;
        end else begin
          if (meas_cnt > target) tune_dec[bit_ptr] = 1'b0;
          if (bit_ptr != '0) begin
            tune_dec[bit_ptr - BIT_W'(1)] = 1'b1;
            bit_nx = bit_ptr - BIT_W'(1);
          end else begin
            // All bits decided: re-measure once at the final code.
            verify_nx = 1'b1;
          end
          tune_nx  = tune_dec;
          tmr_nx   = SETTLE_LOAD;
          state_nx = CAL_SETTLE;
        end
      end

      CAL_DONE: begin
        done_nx  = 1'b1;
        state_nx = CAL_IDLE;
      end

      default: state_nx = CAL_IDLE;
    endcase
  end

  assign cal_busy   = (state != CAL_IDLE);
  assign vcoin_hold = cal_busy;

endmodule
